uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
UART transmitter that sits directly downstream of the byte FIFO. It pops bytes from the FIFO's first-word-fall-through output and serialises each one onto the TX pin as an asynchronous frame: start bit, data bits LSB first, optional parity, stop bit(s). It is the board's console output path for the 27 MHz Tang Nano 20K design.

Parameters:
CLK_FREQ, 27000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bits per second; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, truncated (234 at defaults); must be >= 2
DATA_BITS, 8, data bits per frame, 5..8; must not exceed DATA_WIDTH
DATA_WIDTH, 8, width of the FIFO data bus; only bits [DATA_BITS-1:0] are transmitted
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tx_enable  input  1  when high, new frames may start; when low, no new pop occurs
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0
fifo_read_en  output  1  single-cycle pop strobe to the FIFO
tx  output  1  serial line, idle high, registered
busy  output  1  high while a frame is in flight (START..STOP)
frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset values (async, take effect immediately): tx=1, busy=0, fifo_read_en=0, frame_done=0, state=IDLE, counters=0.
- States: IDLE, START, DATA, PARITY (skipped when PARITY=0), STOP.
- Pop rule: fifo_read_en is combinational and equals tx_enable & ~fifo_empty & (state==IDLE, or last cycle of the last stop bit). It is forced 0 while reset is high. On the same edge the module captures fifo_data[DATA_BITS-1:0] into the shift register, computes parity, and enters START. There is never more than one pop per frame.
- Bit timing: a baud counter runs 0..CLKS_PER_BIT-1. Each bit lasts exactly CLKS_PER_BIT cycles. tx is registered, so it goes low in the first cycle after the pop edge.
- START: tx=0. DATA: tx=shift[0]; the register shifts right at each bit end; a bit index counts 0..DATA_BITS-1. PARITY: tx = XOR of the data bits for even parity, its inverse for odd parity. STOP: tx=1 for STOP_BITS bit times.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- End of frame: frame_done=1 for one cycle (the last STOP cycle).
  - If the pop rule holds in that cycle, the next frame's START follows with no idle gap (back-to-back).
  - Otherwise the block returns to IDLE with tx=1.
- busy=1 from the first START cycle through the last STOP cycle inclusive. busy=0 in IDLE.
- tx_enable deasserted mid-frame: the current frame completes unchanged and no further pop occurs.
- fifo_empty asserting mid-frame: no effect on the current frame.
- Reset mid-frame: tx returns high immediately, the byte is discarded, and no pop occurs while reset is high. After release, the block resumes from IDLE.
- Counter widths: the baud counter is $clog2(CLKS_PER_BIT) bits; the bit index is $clog2(DATA_BITS+1) bits. Neither counter may wrap within a bit time.

Test Plan:
(Sim parameters unless noted: CLK_FREQ=16, BAUD_RATE=1, so CLKS_PER_BIT=16; DATA_BITS=8, STOP_BITS=1.)
1. PARITY=0, FIFO holds 0x48, tx_enable=1 -> exactly one fifo_read_en pulse. tx is low 16 cycles, then 0,0,0,1,0,0,1,0 at 16 cycles each, then high 16 cycles. Frame is 160 cycles; frame_done pulses on cycle 160; busy high for exactly 160 cycles.
2. FIFO holds 0x41,0x42,0x43 -> three pops spaced 160 cycles apart. No idle cycles between frames (the next start bit begins the cycle after frame_done). The block returns to IDLE with tx=1 after the third frame.
3. Byte 0x07 with PARITY=2 -> parity bit 1; with PARITY=1 -> parity bit 0. STOP_BITS=2 frame is 192 cycles.
4. fifo_empty held 1 for 1000 cycles with tx_enable=1 -> fifo_read_en never asserts, tx=1, busy=0.
5. Reset asserted at cycle 50 of a frame (DATA state) for 3 cycles -> tx=1 and busy=0 in the same cycle reset rises. No pop during reset. After release with FIFO non-empty, a fresh frame starts with a single pop.
6. tx_enable dropped at cycle 20 of a frame with two bytes queued -> the current frame completes (frame_done pulses), then no pop and tx stays 1 until tx_enable returns.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a first-word-fall-through byte FIFO onto the TX pin.
// Frames are start, DATA_BITS data bits LSB first, optional parity, then STOP_BITS stop bits.
module uart_tx_fifo_drain #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic              ODD_PAR   = (PARITY == 1);

  // Handshake: fifo_read_en is a pop strobe; the FIFO head word is consumed on
  // the rising clock edge where fifo_read_en=1, and fifo_data must be valid
  // (fifo_empty=0) in that cycle. The FIFO has no backpressure on this side.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;

  logic baud_last;
  logic stop_end;
  logic pop;

  always_comb begin
    baud_last = (baud_q == BAUD_LAST);
    stop_end  = (state_q == S_STOP) && baud_last && (idx_q == STOP_LAST);
    pop       = ~reset & tx_enable & ~fifo_empty & ((state_q == S_IDLE) | stop_end);

    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    baud_d   = '0;
    tx_d     = 1'b1;

    if (state_q != S_IDLE) begin
      baud_d = baud_last ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    // A pop overrides the end-of-frame return to IDLE, giving back-to-back frames.
    if (pop) begin
      state_d  = S_START;
      baud_d   = '0;
      idx_d    = '0;
      shift_d  = fifo_data[DATA_BITS-1:0];
      parity_d = (^fifo_data[DATA_BITS-1:0]) ^ ODD_PAR;
    end

    // tx is registered, so it is derived from where the FSM is headed.
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  assign fifo_read_en = pop;
  assign tx           = tx_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = stop_end;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: three instances cover no/even/odd parity and 1/2 stop bits.
// Outputs are logged each cycle on the falling edge and compared against a hand-built frame model.
module tb_uart_tx_fifo_drain;

  localparam int N_LOG = 4096;
  localparam int CPB   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] en, empty, rd, txs, busys, fds;
  logic [7:0] data0, data1, data2;

  always #5 clk = ~clk;

  // inst 0: no parity, 1 stop; inst 1: even parity, 2 stop; inst 2: odd parity, 1 stop
  uart_tx_fifo_drain #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .DATA_WIDTH(8),
                       .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .tx_enable(en[0]), .fifo_empty(empty[0]), .fifo_data(data0),
    .fifo_read_en(rd[0]), .tx(txs[0]), .busy(busys[0]), .frame_done(fds[0]));
  uart_tx_fifo_drain #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .DATA_WIDTH(8),
                       .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .tx_enable(en[1]), .fifo_empty(empty[1]), .fifo_data(data1),
    .fifo_read_en(rd[1]), .tx(txs[1]), .busy(busys[1]), .frame_done(fds[1]));
  uart_tx_fifo_drain #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .DATA_WIDTH(8),
                       .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(reset), .tx_enable(en[2]), .fifo_empty(empty[2]), .fifo_data(data2),
    .fifo_read_en(rd[2]), .tx(txs[2]), .busy(busys[2]), .frame_done(fds[2]));

  logic [7:0] fq [0:2][0:15];
  int         head [0:2];
  int         cnt  [0:2];

  logic tx_l   [0:2][0:N_LOG-1];
  logic busy_l [0:2][0:N_LOG-1];
  logic rd_l   [0:2][0:N_LOG-1];
  logic fd_l   [0:2][0:N_LOG-1];

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic refresh();
    for (int d = 0; d < 3; d++) empty[d] = (cnt[d] == 0);
    data0 = fq[0][head[0]];
    data1 = fq[1][head[1]];
    data2 = fq[2][head[2]];
  endtask

  task automatic push(input int d, input logic [7:0] b);
    fq[d][(head[d] + cnt[d]) % 16] = b;
    cnt[d]++;
    refresh();
  endtask

  // One clock: log on the falling edge, then retire any pop seen at the rising edge.
  task automatic cycle();
    logic [2:0] r;
    @(negedge clk);
    if (cyc < N_LOG) begin
      for (int d = 0; d < 3; d++) begin
        tx_l[d][cyc]   = txs[d];
        busy_l[d][cyc] = busys[d];
        rd_l[d][cyc]   = rd[d];
        fd_l[d][cyc]   = fds[d];
      end
    end
    r = rd;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (r[d] && cnt[d] > 0) begin
        head[d] = (head[d] + 1) % 16;
        cnt[d]--;
      end
    end
    refresh();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic int count_ones(input int sel, input int d, input int from, input int to);
    int c = 0;
    for (int i = from; i <= to; i++) begin
      if (sel == 0 && rd_l[d][i] === 1'b1) c++;
      if (sel == 1 && tx_l[d][i] === 1'b1) c++;
      if (sel == 2 && busy_l[d][i] === 1'b1) c++;
    end
    return c;
  endfunction

  task automatic find_pop(input string tag, input int d, input int from, input int to,
                          output int p);
    p = -1;
    for (int i = to; i >= from; i--) if (rd_l[d][i] === 1'b1) p = i;
    chk(tag, (p >= 0), 1);
  endtask

  // Line level k cycles after the pop edge (k = 1 is the first start-bit cycle).
  function automatic logic exp_tx(input int k, input logic [7:0] b, input int par);
    int bp = (k - 1) / CPB;
    if (bp == 0) return 1'b0;
    if (bp <= 8) return b[bp-1];
    if (par != 0 && bp == 9) return (^b) ^ (par == 1);
    return 1'b1;
  endfunction

  task automatic check_frame(input string tag, input int d, input int p, input logic [7:0] b,
                             input int par, input int nstop);
    int len, bad_tx, bad_busy, bad_fd, bad_rd;
    if (p < 0) return;
    len = (9 + ((par != 0) ? 1 : 0) + nstop) * CPB;
    bad_tx = 0; bad_busy = 0; bad_fd = 0; bad_rd = 0;
    for (int k = 1; k <= len; k++) begin
      if (tx_l[d][p+k] !== exp_tx(k, b, par)) bad_tx++;
      if (busy_l[d][p+k] !== 1'b1) bad_busy++;
      if (fd_l[d][p+k] !== (k == len)) bad_fd++;
      if (k < len && rd_l[d][p+k] !== 1'b0) bad_rd++;
    end
    chk({tag, "_tx_bad_cycles"}, bad_tx, 0);
    chk({tag, "_busy_bad_cycles"}, bad_busy, 0);
    chk({tag, "_frame_done_bad_cycles"}, bad_fd, 0);
    chk({tag, "_extra_pop_cycles"}, bad_rd, 0);
  endtask

  initial begin
    int s, p, p1;
    reset = 1'b1;
    en    = 3'b000;
    for (int d = 0; d < 3; d++) begin
      head[d] = 0;
      cnt[d]  = 0;
      for (int i = 0; i < 16; i++) fq[d][i] = 8'h00;
    end
    refresh();

    // reset state, with a byte already waiting and tx_enable high on inst 0
    push(0, 8'h99);
    en[0] = 1'b1;
    run(3);
    chk("reset_tx", {tx_l[0][2], tx_l[1][2], tx_l[2][2]}, 3'b111);
    chk("reset_busy", {busy_l[0][2], busy_l[1][2], busy_l[2][2]}, 3'b000);
    chk("reset_no_pop", count_ones(0, 0, 0, 2), 0);
    chk("reset_frame_done", {fd_l[0][2], fd_l[1][2], fd_l[2][2]}, 3'b000);
    head[0] = 0; cnt[0] = 0;
    refresh();
    reset = 1'b0;

    // empty FIFO with tx_enable high: line stays idle
    s = cyc;
    run(1000);
    chk("idle_pops", count_ones(0, 0, s, cyc - 1), 0);
    chk("idle_tx_high_cycles", count_ones(1, 0, s, cyc - 1), 1000);
    chk("idle_busy_cycles", count_ones(2, 0, s, cyc - 1), 0);

    // single byte 0x48
    push(0, 8'h48);
    s = cyc;
    run(170);
    find_pop("t1_pop_found", 0, s, s + 2, p);
    chk("t1_pop_count", count_ones(0, 0, s, cyc - 1), 1);
    chk("t1_busy_cycles", count_ones(2, 0, s, cyc - 1), 160);
    check_frame("t1", 0, p, 8'h48, 0, 1);
    chk("t1_first_data_bit", tx_l[0][s + 17], 1'b0);
    chk("t1_bit3_is_one", tx_l[0][s + 16 + 3 * 16 + 8], 1'b1);
    chk("t1_idle_after", {tx_l[0][s + 161], busy_l[0][s + 161]}, 2'b10);

    // three bytes back to back
    push(0, 8'h41); push(0, 8'h42); push(0, 8'h43);
    s = cyc;
    run(500);
    find_pop("t2_pop_found", 0, s, s + 2, p1);
    chk("t2_pop_count", count_ones(0, 0, s, cyc - 1), 3);
    chk("t2_pop2_at_done", rd_l[0][s + 160], 1'b1);
    chk("t2_pop3_at_done", rd_l[0][s + 320], 1'b1);
    check_frame("t2_f1", 0, p1, 8'h41, 0, 1);
    check_frame("t2_f2", 0, p1 + 160, 8'h42, 0, 1);
    check_frame("t2_f3", 0, p1 + 320, 8'h43, 0, 1);
    chk("t2_busy_cycles", count_ones(2, 0, s, cyc - 1), 480);
    chk("t2_idle_after", {tx_l[0][s + 481], busy_l[0][s + 481]}, 2'b10);

    // 0x07 with even parity / 2 stop bits and odd parity / 1 stop bit
    en[1] = 1'b1; en[2] = 1'b1;
    push(1, 8'h07); push(2, 8'h07);
    s = cyc;
    run(200);
    find_pop("t3_even_pop_found", 1, s, s + 2, p);
    check_frame("t3_even", 1, p, 8'h07, 2, 2);
    find_pop("t3_odd_pop_found", 2, s, s + 2, p);
    check_frame("t3_odd", 2, p, 8'h07, 1, 1);
    chk("t3_even_parity_bit", tx_l[1][s + 9 * 16 + 8], 1'b1);
    chk("t3_odd_parity_bit", tx_l[2][s + 9 * 16 + 8], 1'b0);
    chk("t3_even_busy_cycles", count_ones(2, 1, s, cyc - 1), 192);
    chk("t3_odd_busy_cycles", count_ones(2, 2, s, cyc - 1), 176);
    chk("t3_done_at_192", {fd_l[1][s + 191], fd_l[1][s + 192]}, 2'b01);

    // reset in the middle of a data bit
    push(0, 8'h55); push(0, 8'h3C);
    s = cyc;
    run(50);
    chk("t5_pop_before_reset", rd_l[0][s], 1'b1);
    chk("t5_in_data", {busy_l[0][s + 49], tx_l[0][s + 49]}, 2'b11);
    reset = 1'b1;
    #1;
    chk("t5_tx_immediate", txs[0], 1'b1);
    chk("t5_busy_immediate", busys[0], 1'b0);
    chk("t5_no_pop_immediate", rd[0], 1'b0);
    s = cyc;
    run(3);
    chk("t5_no_pop_during_reset", count_ones(0, 0, s, cyc - 1), 0);
    reset = 1'b0;
    s = cyc;
    run(180);
    chk("t5_pop_count_after", count_ones(0, 0, s, cyc - 1), 1);
    find_pop("t5_pop_found", 0, s, s + 2, p);
    check_frame("t5", 0, p, 8'h3C, 0, 1);

    // tx_enable dropped mid-frame with two bytes queued
    push(0, 8'hA5); push(0, 8'h5A);
    s = cyc;
    run(21);
    find_pop("t6_pop_found", 0, s, s + 2, p);
    en[0] = 1'b0;
    run(200);
    check_frame("t6_f1", 0, p, 8'hA5, 0, 1);
    chk("t6_no_pop_while_disabled", count_ones(0, 0, s + 1, cyc - 1), 0);
    chk("t6_tx_idle_cycles", count_ones(1, 0, s + 161, cyc - 1), cyc - 1 - (s + 161) + 1);
    chk("t6_busy_after", busy_l[0][cyc - 1], 1'b0);
    en[0] = 1'b1;
    s = cyc;
    run(170);
    find_pop("t6_resume_pop_found", 0, s, s + 2, p);
    chk("t6_resume_pop_count", count_ones(0, 0, s, cyc - 1), 1);
    check_frame("t6_f2", 0, p, 8'h5A, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
